pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator directly upstream of the fetch unit. It drives the fetch unit's PC-valid/PC inputs and its pipe-flush input.
- Sequences the PC from a boot vector and holds it stable while the fetch stage or a downstream stage stalls.
- Applies jump redirects from execute, deferring a redirect that arrives mid-fetch until the in-flight bus transaction completes.
- Supports halt/resume for debug.

Parameters:
- AW, 32, address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BOOT_DLY, 4, cycles after reset release before the first fetch (memory warm-up); range 0..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_holding  in  1  combined stall: fetch-unit holding OR downstream stall; PC must not advance while high.
- i_jump_valid  in  1  redirect request from execute (single-cycle pulse).
- i_jump_addr  in  AW  redirect target.
- i_halt_req  in  1  debug halt request (level).
- i_resume  in  1  debug resume (pulse).
- o_pc_valid  out  1  fetch request valid; connects to the fetch unit's PC-valid input.
- o_pc  out  AW  fetch address; connects to the fetch unit's PC input.
- o_flush  out  1  discard the instruction being latched this cycle; connects to the fetch unit's jump-valid input.
- o_misalign  out  1  one-cycle pulse: an accepted jump target had bits [1:0] != 0.
- o_halted  out  1  high while in HALT.

Behaviour:
- Async reset:
  - state=BOOT, cnt=BOOT_DLY, o_pc=RESET_PC, o_pc_valid=0.
  - o_flush=0, o_misalign=0, o_halted=0, pend_addr=0.
- States: BOOT, RUN, REDIR, HALT. o_pc_valid=1 only in RUN and REDIR.
- BOOT:
  - cnt decrements each cycle; when cnt==0, go to RUN next cycle with o_pc=RESET_PC.
  - BOOT_DLY=0 enters RUN on the first cycle after reset release.
  - i_jump_valid is ignored in BOOT.
- RUN, priority from highest:
  1. i_jump_valid && !i_holding: o_pc<=i_jump_addr with [1:0] forced to 0. o_flush=1 combinationally in the same cycle. o_misalign<=|i_jump_addr[1:0].
  2. i_jump_valid && i_holding: pend_addr<=target (bits [1:0] cleared), go to REDIR. o_pc holds. o_flush=0.
  3. i_holding: o_pc holds (bus command must stay stable).
  4. i_halt_req: o_pc<=o_pc+4, go to HALT, so o_pc_valid=0 next cycle.
  5. Otherwise o_pc<=o_pc+4.
- PC arithmetic: +4 modulo 2^AW, wrapping from all-ones-minus-3 to 0 silently.
- REDIR:
  - o_pc holds. o_pc_valid stays 1 so the in-flight fetch completes.
  - A new i_jump_valid overwrites pend_addr (latest wins).
  - When !i_holding: o_flush=1 (kills the stale instruction latched this cycle), o_pc<=pend_addr, go to RUN.
  - If i_jump_valid is also high in that cycle, its target replaces pend_addr as the loaded PC.
  - i_halt_req is deferred until the redirect resolves.
- HALT:
  - o_pc_valid=0, o_halted=1, o_pc holds the next-PC.
  - i_resume goes to RUN.
  - i_jump_valid in HALT: o_pc<=target, o_flush=1, stay in HALT (debugger PC write).
  - If i_jump_valid and i_resume arrive together, the jump applies and the block enters RUN.
- o_flush is never asserted in BOOT. o_misalign is registered, one cycle after acceptance.
- Reset asserted mid-operation (any state, including REDIR) returns all state and outputs to their reset values asynchronously; a pending redirect is lost.

Decomposition:
- Shared package pc_gen_pkg:
  - typedef enum logic [1:0] {BOOT, RUN, REDIR, HALT} pcg_state_t.
  - localparam INSTR_BYTES=4.
  - RESET_PC default constant.
- No sub-module; the boot counter is inline.

Test Plan:
- Reset release, BOOT_DLY=4, i_holding=0 -> o_pc_valid rises on cycle 5; o_pc sequence 0x0,0x4,0x8,...
- In RUN at o_pc=0x10, jump to 0x100 with i_holding=0 -> o_flush=1 that cycle; next o_pc=0x100.
- At o_pc=0x20 with i_holding=1: jump 0x200, then jump 0x300 two cycles later, then i_holding drops -> o_pc stays 0x20 throughout; o_flush=1 on the release cycle; next o_pc=0x300.
- Jump to 0x103 -> next o_pc=0x100; o_misalign pulses for exactly 1 cycle.
- i_halt_req at o_pc=0x40 -> o_pc_valid=0, o_halted=1, o_pc=0x44; i_resume -> fetch resumes at 0x44.
- Reset asserted while in REDIR with pend_addr=0x500 -> outputs return to reset values immediately; after release, fetch starts at RESET_PC, not 0x500.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the program-counter generator.
//   pcg_state_t   - sequencer states (BOOT, RUN, REDIR, HALT)
//   INSTR_BYTES   - sequential PC increment
//   PCG_RESET_PC  - default first fetch address after reset
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2,
        HALT  = 2'd3
    } pcg_state_t;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] PCG_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator feeding the fetch unit.
//   Boots after BOOT_DLY cycles at RESET_PC, then issues sequential fetch
//   addresses, holding the PC stable while i_holding is high. Jump redirects
//   from execute either apply immediately or, when a fetch is in flight, are
//   parked until the bus is released. Debug halt/resume stops fetching and
//   allows PC writes through the jump port.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_holding      - combined fetch/downstream stall; PC must not advance
//   i_jump_valid   - redirect request pulse; i_jump_addr is the target
//   i_halt_req     - debug halt request (level)
//   i_resume       - debug resume pulse
//   o_pc_valid     - fetch request valid (RUN and REDIR only)
//   o_pc           - fetch address
//   o_flush        - discard the instruction latched this cycle
//   o_misalign     - one-cycle pulse after accepting a target with [1:0] != 0
//   o_halted       - high while halted
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned          AW       = 32,
    parameter logic [AW-1:0]        RESET_PC = AW'(PCG_RESET_PC),
    parameter int unsigned          BOOT_DLY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_holding,
    input  logic          i_jump_valid,
    input  logic [AW-1:0] i_jump_addr,
    input  logic          i_halt_req,
    input  logic          i_resume,
    output logic          o_pc_valid,
    output logic [AW-1:0] o_pc,
    output logic          o_flush,
    output logic          o_misalign,
    output logic          o_halted
);

    pcg_state_t    r_state;
    logic [7:0]    r_cnt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pend;
    logic          r_pc_valid;
    logic          r_misalign;
    logic          r_halted;

    logic [AW-1:0] w_target;
    logic [AW-1:0] w_pc_next;
    logic          w_target_mis;

    // Targets are always word-aligned; the dropped low bits only feed o_misalign.
    assign w_target     = {i_jump_addr[AW-1:2], 2'b00};
    assign w_target_mis = |i_jump_addr[1:0];
    assign w_pc_next    = r_pc + AW'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_cnt      <= 8'(BOOT_DLY);
            r_pc       <= RESET_PC;
            r_pend     <= '0;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                BOOT: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= RUN;
                        r_pc       <= RESET_PC;
                        r_pc_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                RUN: begin
                    if (i_jump_valid && !i_holding) begin
                        r_pc       <= w_target;
                        r_misalign <= w_target_mis;
                    end else if (i_jump_valid) begin
                        // Fetch in flight: keep the bus command stable and park the target.
                        r_pend     <= w_target;
                        r_misalign <= w_target_mis;
                        r_state    <= REDIR;
                    end else if (i_holding) begin
                        r_pc <= r_pc;
                    end else if (i_halt_req) begin
                        r_pc       <= w_pc_next;
                        r_state    <= HALT;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                    end else begin
                        r_pc <= w_pc_next;
                    end
                end

                REDIR: begin
                    if (i_jump_valid) begin
                        r_misalign <= w_target_mis;
                    end
                    if (!i_holding) begin
                        // A jump arriving on the release cycle is newer than the parked one.
                        r_pc    <= i_jump_valid ? w_target : r_pend;
                        r_state <= RUN;
                    end else if (i_jump_valid) begin
                        r_pend <= w_target;
                    end
                end

                HALT: begin
                    if (i_jump_valid) begin
                        r_pc       <= w_target;
                        r_misalign <= w_target_mis;
                    end
                    if (i_resume) begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    // Flush is combinational so the fetch unit drops the instruction latched
    // on the same edge that loads the new PC.
    always_comb begin
        o_flush = 1'b0;
        case (r_state)
            RUN:     o_flush = i_jump_valid && !i_holding;
            REDIR:   o_flush = !i_holding;
            HALT:    o_flush = i_jump_valid;
            default: o_flush = 1'b0;
        endcase
    end

    assign o_pc_valid = r_pc_valid;
    assign o_pc       = r_pc;
    assign o_misalign = r_misalign;
    assign o_halted   = r_halted;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        i_holding;
    logic        i_jump_valid;
    logic [31:0] i_jump_addr;
    logic        i_halt_req;
    logic        i_resume;
    logic        o_pc_valid;
    logic [31:0] o_pc;
    logic        o_flush;
    logic        o_misalign;
    logic        o_halted;

    int checks;
    int failures;

    pc_gen #(
        .AW       (32),
        .RESET_PC (32'h0000_0000),
        .BOOT_DLY (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_holding    (i_holding),
        .i_jump_valid (i_jump_valid),
        .i_jump_addr  (i_jump_addr),
        .i_halt_req   (i_halt_req),
        .i_resume     (i_resume),
        .o_pc_valid   (o_pc_valid),
        .o_pc         (o_pc),
        .o_flush      (o_flush),
        .o_misalign   (o_misalign),
        .o_halted     (o_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        i_holding    = 1'b0;
        i_jump_valid = 1'b0;
        i_jump_addr  = '0;
        i_halt_req   = 1'b0;
        i_resume     = 1'b0;

        // Reset state
        #1;
        chk("rst_valid",    32'(o_pc_valid), 32'd0);
        chk("rst_pc",       o_pc,            32'h0);
        chk("rst_flush",    32'(o_flush),    32'd0);
        chk("rst_halted",   32'(o_halted),   32'd0);
        chk("rst_misalign", 32'(o_misalign), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Boot: four silent cycles, fetch at RESET_PC on the fifth edge
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("boot_valid_%0d", i), 32'(o_pc_valid), 32'd0);
        end
        tick();
        chk("boot_valid_5", 32'(o_pc_valid), 32'd1);
        chk("boot_pc",      o_pc,            32'h0);
        tick();
        chk("seq_pc_4", o_pc, 32'h4);
        tick();
        chk("seq_pc_8", o_pc, 32'h8);

        // Plain stall holds the PC
        i_holding = 1'b1;
        tick();
        chk("hold_pc", o_pc, 32'h8);
        i_holding = 1'b0;
        tick();
        chk("seq_pc_c", o_pc, 32'hC);
        tick();
        chk("seq_pc_10", o_pc, 32'h10);

        // Immediate jump at 0x10
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h100;
        #1;
        chk("jmp_flush", 32'(o_flush), 32'd1);
        tick();
        i_jump_valid = 1'b0;
        #1;
        chk("jmp_pc",       o_pc,            32'h100);
        chk("jmp_flush_lo", 32'(o_flush),    32'd0);
        chk("jmp_mis_lo",   32'(o_misalign), 32'd0);

        // Move to 0x20, then deferred redirect with latest-wins
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h20;
        tick();
        chk("pc_20", o_pc, 32'h20);
        i_holding   = 1'b1;
        i_jump_addr = 32'h200;
        #1;
        chk("redir_req_flush", 32'(o_flush), 32'd0);
        tick();
        i_jump_valid = 1'b0;
        #1;
        chk("redir_pc_a",    o_pc,            32'h20);
        chk("redir_valid",   32'(o_pc_valid), 32'd1);
        chk("redir_flush_a", 32'(o_flush),    32'd0);
        tick();
        chk("redir_pc_b", o_pc, 32'h20);
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h300;
        tick();
        i_jump_valid = 1'b0;
        #1;
        chk("redir_pc_c", o_pc, 32'h20);
        i_holding = 1'b0;
        #1;
        chk("redir_rel_flush", 32'(o_flush), 32'd1);
        tick();
        chk("redir_pc_300",   o_pc,         32'h300);
        chk("redir_flush_lo", 32'(o_flush), 32'd0);

        // Misaligned target
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h103;
        tick();
        i_jump_valid = 1'b0;
        #1;
        chk("mis_pc",    o_pc,            32'h100);
        chk("mis_pulse", 32'(o_misalign), 32'd1);
        tick();
        chk("mis_pc_next", o_pc,            32'h104);
        chk("mis_pulse_0", 32'(o_misalign), 32'd0);

        // Halt at 0x40 and resume
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h40;
        tick();
        i_jump_valid = 1'b0;
        chk("pc_40", o_pc, 32'h40);
        i_halt_req = 1'b1;
        tick();
        chk("halt_valid",  32'(o_pc_valid), 32'd0);
        chk("halt_halted", 32'(o_halted),   32'd1);
        chk("halt_pc",     o_pc,            32'h44);
        i_halt_req = 1'b0;
        tick();
        chk("halt_pc_hold", o_pc, 32'h44);
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        chk("resume_valid",  32'(o_pc_valid), 32'd1);
        chk("resume_halted", 32'(o_halted),   32'd0);
        chk("resume_pc",     o_pc,            32'h44);
        tick();
        chk("resume_pc_48", o_pc, 32'h48);

        // Debugger PC write while halted, then jump+resume together
        i_halt_req = 1'b1;
        tick();
        i_halt_req = 1'b0;
        chk("halt2_pc", o_pc, 32'h4C);
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h80;
        #1;
        chk("halt_jmp_flush", 32'(o_flush), 32'd1);
        tick();
        chk("halt_jmp_pc",     o_pc,          32'h80);
        chk("halt_jmp_halted", 32'(o_halted), 32'd1);
        i_jump_addr = 32'h90;
        i_resume    = 1'b1;
        tick();
        i_jump_valid = 1'b0;
        i_resume     = 1'b0;
        chk("jmp_resume_pc",    o_pc,            32'h90);
        chk("jmp_resume_valid", 32'(o_pc_valid), 32'd1);

        // Wrap from 0xFFFFFFFC to 0
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'hFFFF_FFFC;
        tick();
        i_jump_valid = 1'b0;
        chk("wrap_top", o_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", o_pc, 32'h0);

        // Reset while in REDIR drops the parked target
        i_holding    = 1'b1;
        i_jump_valid = 1'b1;
        i_jump_addr  = 32'h500;
        tick();
        i_jump_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("rst2_valid",  32'(o_pc_valid), 32'd0);
        chk("rst2_pc",     o_pc,            32'h0);
        chk("rst2_flush",  32'(o_flush),    32'd0);
        chk("rst2_halted", 32'(o_halted),   32'd0);
        i_holding = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("boot2_valid_%0d", i), 32'(o_pc_valid), 32'd0);
        end
        tick();
        chk("boot2_valid", 32'(o_pc_valid), 32'd1);
        chk("boot2_pc",    o_pc,            32'h0);
        tick();
        chk("boot2_pc_4", o_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
